// File: rtl/alu_pkg.sv
// ============================================================================
//  Module   : alu_pkg
//  Desc     : Shared opcodes, FSM state, op-class and flag bundle types for
//             the sequential ALU.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam logic [2:0] c_OP_ADD = 3'b000;
  localparam logic [2:0] c_OP_SUB = 3'b001;
  localparam logic [2:0] c_OP_SRA = 3'b010;
  localparam logic [2:0] c_OP_SRL = 3'b011;
  localparam logic [2:0] c_OP_SLL = 3'b100;
  localparam logic [2:0] c_OP_AND = 3'b101;
  localparam logic [2:0] c_OP_OR  = 3'b110;
  localparam logic [2:0] c_OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Selects which of carry/overflow are meaningful for a result
  typedef enum logic [2:0] {
    CLS_ARITH = 3'd0,
    CLS_SHIFT = 3'd1,
    CLS_LOGIC = 3'd2,
    CLS_MUL   = 3'd3,
    CLS_ILL   = 3'd4
  } opcls_t;

  typedef struct packed {
    logic c;
    logic v;
    logic n;
    logic z;
  } flags_t;

endpackage

`default_nettype wire

// File: rtl/alu_flags.sv
// ============================================================================
//  Module   : alu_flags
//  Desc     : Combinational C/V/N/Z generation from a result, its raw carry
//             and overflow, and the class of the operation that produced it.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_flags
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_y,
  input  logic             i_carry,
  input  logic             i_ovf,
  input  opcls_t           i_cls,
  output flags_t           o_flags
);

  // Mask carry/overflow by op class; illegal ops report a forced zero result
  always_comb begin
    o_flags.n = i_y[WIDTH-1];
    o_flags.z = (i_y == '0);
    o_flags.c = 1'b0;
    o_flags.v = 1'b0;
    case (i_cls)
      CLS_ARITH, CLS_MUL: begin
        o_flags.c = i_carry;
        o_flags.v = i_ovf;
      end
      CLS_SHIFT: begin
        o_flags.c = i_carry;
      end
      CLS_ILL: begin
        o_flags.n = 1'b0;
        o_flags.z = 1'b1;
      end
      default: begin
        o_flags.c = 1'b0;
        o_flags.v = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
//  Module   : alu_seq
//  Desc     : Handshaked sequential ALU. Add/sub/logic complete on the accept
//             edge; shifts advance one bit per cycle; optional shift-add
//             multiply (define ALU_SEQ_MUL_EN) takes WIDTH cycles. Result,
//             flags and ERR are registered and held while OUT_VALID is high.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [2:0]       OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] Y,
  output logic             C,
  output logic             V,
  output logic             N,
  output logic             Z,
  output logic             ERR
);

  localparam logic [SHW-1:0] c_MUL_STEPS = SHW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_sh;
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_y;
  flags_t           r_flags;
  logic             r_err;

  logic             w_idle;
  logic             w_busy;
  logic             w_accept;
  logic [2:0]       w_op;
  logic [SHW-1:0]   w_amt;
  logic             w_is_shift;
  logic             w_is_mul;
  logic             w_single;
  logic             w_last_step;
  logic             w_load_result;

  logic [WIDTH-1:0] w_sh_src;
  logic [WIDTH-1:0] w_sh_step;
  logic             w_sh_co;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_add_v;
  logic             w_sub_v;

  logic [WIDTH-1:0] w_mul_lo;
  logic             w_mul_hi_nz;

  logic [WIDTH-1:0] w_res_y;
  logic             w_res_c;
  logic             w_res_v;
  logic             w_res_err;
  opcls_t           w_res_cls;
  flags_t           w_flags;

  assign w_idle   = (r_state == IDLE);
  assign w_busy   = (r_state == BUSY);
  assign w_accept = w_idle && IN_VALID;

  // Live inputs are only consulted on the accept edge; afterwards the latched copy rules
  assign w_op  = w_idle ? OP : r_op;
  assign w_amt = B[SHW-1:0];

  assign w_is_shift = (w_op == c_OP_SRA) || (w_op == c_OP_SRL) || (w_op == c_OP_SLL);

  // Amounts 0 and 1 finish on the accept edge, so shift latency is max(k,1)
  assign w_single    = !(w_is_shift || w_is_mul) || (w_is_shift && (w_amt <= SHW'(1)));
  assign w_last_step = w_busy && (r_cnt == SHW'(1));

  assign w_load_result = (w_accept && w_single) || w_last_step;

  // The accept edge performs the first shift step, BUSY performs the rest
  assign w_sh_src = w_idle ? A : r_sh;

  // One-bit shift step shared by all three shift ops
  always_comb begin
    w_sh_step = w_sh_src;
    w_sh_co   = 1'b0;
    case (w_op)
      c_OP_SRA: begin
        w_sh_step = {w_sh_src[WIDTH-1], w_sh_src[WIDTH-1:1]};
        w_sh_co   = w_sh_src[0];
      end
      c_OP_SRL: begin
        w_sh_step = {1'b0, w_sh_src[WIDTH-1:1]};
        w_sh_co   = w_sh_src[0];
      end
      c_OP_SLL: begin
        w_sh_step = {w_sh_src[WIDTH-2:0], 1'b0};
        w_sh_co   = w_sh_src[WIDTH-1];
      end
      default: begin
        w_sh_step = w_sh_src;
        w_sh_co   = 1'b0;
      end
    endcase
  end

  assign w_sum   = {1'b0, A} + {1'b0, B};
  assign w_diff  = A - B;
  assign w_add_v = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
  assign w_sub_v = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);

`ifdef ALU_SEQ_MUL_EN
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mc;
  logic [WIDTH-1:0]   r_mb;
  logic [2*WIDTH-1:0] w_acc_src;
  logic [2*WIDTH-1:0] w_mc_src;
  logic [2*WIDTH-1:0] w_acc_next;
  logic               w_mb0;

  assign w_is_mul   = (w_op == c_OP_MUL);
  assign w_acc_src  = w_idle ? '0 : r_acc;
  assign w_mc_src   = w_idle ? {{WIDTH{1'b0}}, A} : r_mc;
  assign w_mb0      = w_idle ? B[0] : r_mb[0];
  assign w_acc_next = w_acc_src + (w_mb0 ? w_mc_src : '0);

  assign w_mul_lo    = w_acc_next[WIDTH-1:0];
  assign w_mul_hi_nz = |w_acc_next[2*WIDTH-1:WIDTH];

  // Shift-add multiplier: one partial product per cycle, bit 0 on the accept edge
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_acc <= '0;
      r_mc  <= '0;
      r_mb  <= '0;
    end else if (w_accept || w_busy) begin
      r_acc <= w_acc_next;
      r_mc  <= w_mc_src << 1;
      r_mb  <= (w_idle ? B : r_mb) >> 1;
    end
  end
`else
  assign w_is_mul    = 1'b0;
  assign w_mul_lo    = '0;
  assign w_mul_hi_nz = 1'b0;
`endif

  // Select the result that gets registered on the finishing edge
  always_comb begin
    w_res_y   = '0;
    w_res_c   = 1'b0;
    w_res_v   = 1'b0;
    w_res_err = 1'b0;
    w_res_cls = CLS_ILL;
    case (w_op)
      c_OP_ADD: begin
        w_res_y   = w_sum[WIDTH-1:0];
        w_res_c   = w_sum[WIDTH];
        w_res_v   = w_add_v;
        w_res_cls = CLS_ARITH;
      end
      c_OP_SUB: begin
        w_res_y   = w_diff;
        w_res_c   = (A >= B);
        w_res_v   = w_sub_v;
        w_res_cls = CLS_ARITH;
      end
      c_OP_SRA, c_OP_SRL, c_OP_SLL: begin
        w_res_cls = CLS_SHIFT;
        if (w_idle && (w_amt == '0)) begin
          w_res_y = A;
          w_res_c = 1'b0;
        end else begin
          w_res_y = w_sh_step;
          w_res_c = w_sh_co;
        end
      end
      c_OP_AND: begin
        w_res_y   = A & B;
        w_res_cls = CLS_LOGIC;
      end
      c_OP_OR: begin
        w_res_y   = A | B;
        w_res_cls = CLS_LOGIC;
      end
      default: begin
        if (w_is_mul) begin
          w_res_y   = w_mul_lo;
          w_res_c   = w_mul_hi_nz;
          w_res_v   = w_mul_hi_nz;
          w_res_cls = CLS_MUL;
        end else begin
          w_res_err = 1'b1;
          w_res_cls = CLS_ILL;
        end
      end
    endcase
  end

  alu_flags #(
    .WIDTH (WIDTH)
  ) u_flags (
    .i_y     (w_res_y),
    .i_carry (w_res_c),
    .i_ovf   (w_res_v),
    .i_cls   (w_res_cls),
    .o_flags (w_flags)
  );

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (IN_VALID) begin
          w_state_next = w_single ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (r_cnt == SHW'(1)) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        if (OUT_READY) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Operand latch, step counter and registered result
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_op    <= '0;
      r_sh    <= '0;
      r_cnt   <= '0;
      r_y     <= '0;
      r_flags <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op  <= OP;
        r_cnt <= w_is_mul ? c_MUL_STEPS : (w_amt - SHW'(1));
      end else if (w_busy) begin
        r_cnt <= r_cnt - SHW'(1);
      end
      if (w_accept || w_busy) begin
        r_sh <= w_sh_step;
      end
      if (w_load_result) begin
        r_y     <= w_res_y;
        r_flags <= w_flags;
        r_err   <= w_res_err;
      end
    end
  end

  assign IN_READY  = w_idle;
  assign OUT_VALID = (r_state == DONE);
  assign Y         = r_y;
  assign C         = r_flags.c;
  assign V         = r_flags.v;
  assign N         = r_flags.n;
  assign Z         = r_flags.z;
  assign ERR       = r_err;

endmodule

`default_nettype wire

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked sequential ALU that replaces the fixed 8-bit combinational ALU in the lab datapath. It takes WIDTH-bit operands and supports variable-amount shifts computed one bit per cycle. An optional iterative multiply is available. Results and C/V/N/Z flags are registered and held under a valid/ready handshake, so the block can sit between the register file and the writeback stage. The seven-segment display drivers stay outside this block.

## Interface
- WIDTH, default 8: operand/result width; legal values ≥ 4, power of two.
- SHW, default $clog2(WIDTH): shift-amount width (derived; do not override).
- CLK  in  1  rising-edge clock.
- RESET  in  1  synchronous, active-high reset.
- IN_VALID  in  1  operation request.
- IN_READY  out  1  block can accept a request.
- OP  in  3  opcode: 000 ADD, 001 SUB, 010 SRA, 011 SRL, 100 SLL, 101 AND, 110 OR, 111 MUL.
- A, B  in  WIDTH  operands; for shifts, amount = B[SHW-1:0].
- OUT_VALID  out  1  result valid.
- OUT_READY  in  1  consumer takes result.
- Y  out  WIDTH  result.
- C, V, N, Z  out  1 each  flags.
- ERR  out  1  illegal opcode flag, qualified by OUT_VALID.

## Operation
- Interface decision: one clock, CLK; reset is synchronous and active-high, RESET.
- The FSM has three states: IDLE, BUSY, DONE.
  - IDLE: IN_READY=1. On IN_VALID, latch OP, A, B and the shift amount.
  - Single-cycle ops (ADD/SUB/AND/OR/illegal) go directly to DONE with the result registered.
  - Shifts and MUL go to BUSY.
- BUSY: shifts perform one 1-bit step per cycle, decrementing a counter. The FSM moves to DONE when the remaining count reaches 0. A shift amount of 0 takes one cycle, with Y=A and C=0.
- DONE: OUT_VALID=1. Y, flags and ERR are held stable until the cycle where OUT_READY=1, then the FSM returns to IDLE. IN_READY=0 in BUSY and DONE; there is no back-to-back accept in the DONE→IDLE cycle.
- ADD: Y=A+B mod 2^WIDTH; C = carry out; V = signed overflow.
- SUB: Y=A-B; C=1 when A≥B unsigned (no borrow); V = signed overflow.
- SRA fills with A[MSB], SRL fills with 0, SLL fills with 0. For all shifts, C = the last bit shifted out and V=0.
- AND/OR: C=V=0.
- All ops: N=Y[WIDTH-1]; Z=(Y==0).
- Illegal opcode: Y=0, C=V=N=0, Z=1, ERR=1.

## Timing
- Reset values: state IDLE; Y=0; C=V=N=Z=0; ERR=0; OUT_VALID=0; IN_READY=1 from the first cycle after reset.
- Latency from the accept edge to OUT_VALID high:
  - 1 cycle for ADD/SUB/AND/OR/illegal.
  - max(k,1) cycles for a shift by k.
  - WIDTH cycles for MUL.
- OUT_VALID stays high indefinitely under backpressure; outputs must not change while it is high.
- RESET asserted in any state, including mid-shift, aborts the operation. On the next cycle all outputs equal their reset values, and no stale result is ever presented.
- Inputs are sampled only on the accept edge; changes to A, B or OP during BUSY have no effect.

## Configuration
- Macro ALU_SEQ_MUL_EN controls the multiplier.
- When defined: OP 111 is an unsigned shift-add multiply, one partial product per cycle over WIDTH cycles.
  - Y = low WIDTH bits of the product.
  - C = V = 1 if the high WIDTH bits are nonzero, else 0.
  - N and Z are computed from Y.
- When undefined: OP 111 is illegal (ERR path, 1-cycle latency), and no multiplier hardware is generated.

## Structure
- Shared package alu_pkg holds:
  - the opcode localparams (ADD…MUL);
  - the state enum (IDLE/BUSY/DONE);
  - the flag bundle typedef {C,V,N,Z}.
- One sub-module, alu_flags: combinational; takes the result, carry-out, overflow and an op-class input, and produces C/V/N/Z. It is reused by the top-level datapath.
- Shift and multiply counters live in alu_seq itself.

## Test plan
- ADD 0x7F+0x01 (WIDTH=8) → Y=0x80, C=0, V=1, N=1, Z=0, OUT_VALID one cycle after accept.
- SUB 0x05-0x05 → Y=0x00, Z=1, C=1, V=0. SUB 0x03-0x05 → Y=0xFE, C=0, N=1.
- SRA 0x90 by 3 → Y=0xF2, C=0, OUT_VALID 3 cycles after accept. SLL 0x81 by 1 → Y=0x02, C=1. SRL 0x55 by 0 → Y=0x55, C=0, 1-cycle latency.
- Backpressure: ADD result with OUT_READY low for 4 cycles → Y and flags held, IN_READY=0 throughout. After OUT_READY=1, IN_READY returns to 1 the next cycle.
- RESET asserted on the 3rd BUSY cycle of SLL by 7 → next cycle OUT_VALID=0, IN_READY=1, Y=0, flags 0.
- OP 111 with A=0x10, B=0x10: with ALU_SEQ_MUL_EN defined → Y=0x00, C=V=1, Z=1 after 8 cycles. Without the macro → ERR=1, Y=0, Z=1 after 1 cycle.
